tile_spawn_controller: RTL and testbench

TILE_SPAWN_CONTROLLER -- requirements
Module: tile_spawn_controller

---
 rtl/tile_spawn_controller.sv | 138 +++++++++++++
 tb/tb_tile_spawn_controller.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/tile_spawn_controller.sv
// Tile spawn controller: places a new 2/4 tile on a 4x4 board snapshot.
// It asks an external random generator for an empty cell for a bounded
// number of cycles. If no usable candidate arrives in that time, it falls
// back to the lowest-index empty cell.
module tile_spawn_controller #(
   parameter int MAX_TRIES = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        spawn_req,
   input  logic [63:0] board_in,
   input  logic        gen_done,
   input  logic [3:0]  gen_pos,
   input  logic        gen_preset,
   output logic [15:0] empty_mask,
   output logic        spawn_busy,
   output logic        spawn_valid,
   output logic [3:0]  spawn_pos,
   output logic [3:0]  spawn_exp,
   output logic [63:0] board_out,
   output logic        board_full
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_SETTLE = 3'd1;
   localparam logic [2:0] ST_SEARCH = 3'd2;
   localparam logic [2:0] ST_SCAN   = 3'd3;
   localparam logic [2:0] ST_EMIT   = 3'd4;

   // A miss while the counter holds this value ends the random search.
   localparam logic [7:0] TRY_LIMIT = 8'(MAX_TRIES - 1);

   logic [2:0]  r_state;
   logic [63:0] r_board;
   logic [7:0]  r_tries;
   logic [3:0]  r_pos;
   logic [3:0]  r_exp;
   logic [63:0] r_board_out;
   logic        r_board_full;

   logic [15:0] w_in_empty;
   logic        w_in_full;
   logic [3:0]  w_gen_cell;
   logic        w_hit;
   logic [3:0]  w_new_exp;
   logic [3:0]  w_scan_pos;
   logic [3:0]  w_place_pos;
   logic [63:0] w_board_ins;

   // Per-cell empty flags for the incoming snapshot and the latched board.
   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_cells
         assign w_in_empty[gi] = (board_in[4*gi +: 4] == 4'd0);
         assign empty_mask[gi] = (r_board[4*gi +: 4] == 4'd0);
      end
   endgenerate

   assign w_in_full = ~|w_in_empty;

   // A generator hit is trusted only if the latched cell is really empty.
   assign w_gen_cell = r_board[{gen_pos, 2'b00} +: 4];
   assign w_hit      = gen_done && (w_gen_cell == 4'd0);
   assign w_new_exp  = gen_preset ? 4'd2 : 4'd1;

   // Priority encoder: the lowest-index empty cell wins.
   always_comb begin
      w_scan_pos = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (empty_mask[i]) w_scan_pos = 4'(i);
      end
   end

   assign w_place_pos = (r_state == ST_SCAN) ? w_scan_pos : gen_pos;

   // The board with the new tile written at the chosen position.
   always_comb begin
      w_board_ins = r_board;
      w_board_ins[{w_place_pos, 2'b00} +: 4] = w_new_exp;
   end

   // Control FSM plus board, try-counter and result registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= ST_IDLE;
         r_board      <= 64'd0;
         r_tries      <= 8'd0;
         r_pos        <= 4'd0;
         r_exp        <= 4'd0;
         r_board_out  <= 64'd0;
         r_board_full <= 1'b0;
      end else begin
         r_board_full <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (spawn_req) begin
                  r_board <= board_in;
                  r_tries <= 8'd0;
                  if (w_in_full) r_board_full <= 1'b1;
                  else           r_state      <= ST_SETTLE;
               end
            end
            // Gives the generator one cycle to see the new mask. Its
            // output is ignored here.
            ST_SETTLE: r_state <= ST_SEARCH;
            ST_SEARCH: begin
               if (w_hit) begin
                  r_board     <= w_board_ins;
                  r_board_out <= w_board_ins;
                  r_pos       <= gen_pos;
                  r_exp       <= w_new_exp;
                  r_state     <= ST_EMIT;
               end else begin
                  if (r_tries != 8'hFF) r_tries <= r_tries + 8'd1;
                  if (r_tries >= TRY_LIMIT) r_state <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               r_board     <= w_board_ins;
               r_board_out <= w_board_ins;
               r_pos       <= w_scan_pos;
               r_exp       <= w_new_exp;
               r_state     <= ST_EMIT;
            end
            ST_EMIT: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign spawn_busy  = (r_state != ST_IDLE);
   assign spawn_valid = (r_state == ST_EMIT);
   assign spawn_pos   = r_pos;
   assign spawn_exp   = r_exp;
   assign board_out   = r_board_out;
   assign board_full  = r_board_full;

endmodule

// File: tb/tb_tile_spawn_controller.sv
// Directed bench for tile_spawn_controller with MAX_TRIES=4.
// Inputs are driven and outputs are checked 1 ns after each rising edge.
// Cycle N means N rising edges after the edge that accepted the request.
module tb_tile_spawn_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        spawn_req;
   logic [63:0] board_in;
   logic        gen_done;
   logic [3:0]  gen_pos;
   logic        gen_preset;
   logic [15:0] empty_mask;
   logic        spawn_busy;
   logic        spawn_valid;
   logic [3:0]  spawn_pos;
   logic [3:0]  spawn_exp;
   logic [63:0] board_out;
   logic        board_full;

   int n_checks = 0;
   int n_pass   = 0;

   tile_spawn_controller #(.MAX_TRIES(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .spawn_req  (spawn_req),
      .board_in   (board_in),
      .gen_done   (gen_done),
      .gen_pos    (gen_pos),
      .gen_preset (gen_preset),
      .empty_mask (empty_mask),
      .spawn_busy (spawn_busy),
      .spawn_valid(spawn_valid),
      .spawn_pos  (spawn_pos),
      .spawn_exp  (spawn_exp),
      .board_out  (board_out),
      .board_full (board_full)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Checks that every output is at its reset value.
   task automatic chk_idle_zero(input string tag);
      chk({tag, "_busy"},  64'(spawn_busy),  64'd0);
      chk({tag, "_valid"}, 64'(spawn_valid), 64'd0);
      chk({tag, "_full"},  64'(board_full),  64'd0);
      chk({tag, "_pos"},   64'(spawn_pos),   64'd0);
      chk({tag, "_exp"},   64'(spawn_exp),   64'd0);
      chk({tag, "_bout"},  board_out,        64'd0);
      chk({tag, "_mask"},  64'(empty_mask),  64'hFFFF);
   endtask

   // Stops the run if the directed sequence ever stalls.
   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; spawn_req = 1'b0; board_in = 64'd0;
      gen_done = 1'b0; gen_pos = 4'd0; gen_preset = 1'b0;
      tick(); tick();
      chk_idle_zero("reset");

      // Release reset together with a request: the very next edge accepts it.
      // Empty board, hit at cell 5 on the first SEARCH cycle.
      rst = 1'b1; spawn_req = 1'b1; board_in = 64'd0;
      tick();                                                 // cycle 1 SETTLE
      $display("T1 first request after reset, hit cell 5 tile 2");
      chk("t1_c1_busy",  64'(spawn_busy),  64'd1);
      chk("t1_c1_valid", 64'(spawn_valid), 64'd0);
      spawn_req = 1'b0; gen_done = 1'b1; gen_pos = 4'd5; gen_preset = 1'b0;
      tick();                                                 // cycle 2 SEARCH
      chk("t1_c2_valid", 64'(spawn_valid), 64'd0);
      tick();                                                 // cycle 3 EMIT
      chk("t1_c3_valid", 64'(spawn_valid), 64'd1);
      chk("t1_pos",      64'(spawn_pos),   64'd5);
      chk("t1_exp",      64'(spawn_exp),   64'd1);
      chk("t1_bout",     board_out,        64'h0000_0000_0010_0000);
      chk("t1_mask",     64'(empty_mask),  64'hFFDF);
      gen_done = 1'b0;
      tick();                                                 // cycle 4 IDLE
      chk("t1_c4_valid", 64'(spawn_valid), 64'd0);
      chk("t1_c4_busy",  64'(spawn_busy),  64'd0);
      chk("t1_hold_pos", 64'(spawn_pos),   64'd5);
      chk("t1_hold_bout", board_out,       64'h0000_0000_0010_0000);

      // Full board: a single board_full pulse and no spawn.
      $display("T2 full board");
      board_in = 64'h1111_1111_1111_1111; spawn_req = 1'b1;
      tick();
      chk("t2_full",     64'(board_full),  64'd1);
      chk("t2_valid",    64'(spawn_valid), 64'd0);
      chk("t2_busy",     64'(spawn_busy),  64'd0);
      chk("t2_mask",     64'(empty_mask),  64'h0000);
      spawn_req = 1'b0;
      tick();
      chk("t2_full_end", 64'(board_full),  64'd0);
      chk("t2_busy_end", 64'(spawn_busy),  64'd0);
      chk("t2_valid2",   64'(spawn_valid), 64'd0);
      chk("t2_hold_pos", 64'(spawn_pos),   64'd5);

      // Only cell 12 is empty. The generator keeps reporting occupied cell 0,
      // which counts as a miss. After 4 SEARCH cycles the controller goes to
      // SCAN and then EMIT at cycle 7.
      $display("T3 timeout to scan, cell 12");
      board_in = 64'h1110_1111_1111_1111; spawn_req = 1'b1;
      gen_done = 1'b0; gen_pos = 4'd0; gen_preset = 1'b1;
      tick();                                                 // cycle 1
      chk("t3_mask", 64'(empty_mask), 64'h1000);
      spawn_req = 1'b0; gen_done = 1'b1;
      for (int c = 2; c <= 6; c++) begin                      // SEARCH x4, SCAN
         tick();
         chk($sformatf("t3_c%0d_valid", c), 64'(spawn_valid), 64'd0);
         chk($sformatf("t3_c%0d_busy", c),  64'(spawn_busy),  64'd1);
      end
      tick();                                                 // cycle 7 EMIT
      chk("t3_c7_valid", 64'(spawn_valid), 64'd1);
      chk("t3_pos",      64'(spawn_pos),   64'd12);
      chk("t3_exp",      64'(spawn_exp),   64'd2);
      chk("t3_bout",     board_out,        64'h1112_1111_1111_1111);
      gen_done = 1'b0;
      tick();
      chk("t3_c8_valid", 64'(spawn_valid), 64'd0);

      // A hit during SETTLE is ignored. A request and a board change during
      // SEARCH are also ignored. A later hit at cell 3 places a 4-tile.
      $display("T4 settle hit ignored, mid-search req ignored, cell 3 tile 4");
      board_in = 64'h0000_0000_0000_0021; spawn_req = 1'b1;
      gen_done = 1'b0; gen_pos = 4'd7; gen_preset = 1'b0;
      tick();                                                 // cycle 1 SETTLE
      chk("t4_mask0", 64'(empty_mask), 64'hFFFC);
      spawn_req = 1'b0; gen_done = 1'b1;                      // sampled in SETTLE
      tick();                                                 // cycle 2 SEARCH
      chk("t4_c2_valid", 64'(spawn_valid), 64'd0);
      gen_done = 1'b0; spawn_req = 1'b1; board_in = 64'hFFFF_FFFF_FFFF_FFFF;
      tick();                                                 // cycle 3 SEARCH
      chk("t4_c3_valid", 64'(spawn_valid), 64'd0);
      chk("t4_c3_busy",  64'(spawn_busy),  64'd1);
      chk("t4_mask1",    64'(empty_mask),  64'hFFFC);
      spawn_req = 1'b0; gen_done = 1'b1; gen_pos = 4'd3; gen_preset = 1'b1;
      tick();                                                 // cycle 4 EMIT
      chk("t4_c4_valid", 64'(spawn_valid), 64'd1);
      chk("t4_pos",      64'(spawn_pos),   64'd3);
      chk("t4_exp",      64'(spawn_exp),   64'd2);
      chk("t4_bout",     board_out,        64'h0000_0000_0000_2021);
      gen_done = 1'b0; board_in = 64'd0;
      for (int c = 5; c <= 8; c++) begin
         tick();
         chk($sformatf("t4_c%0d_valid", c), 64'(spawn_valid), 64'd0);
         chk($sformatf("t4_c%0d_busy", c),  64'(spawn_busy),  64'd0);
      end

      // A hit on the last allowed SEARCH cycle beats the SCAN fallback.
      $display("T5 hit at try limit wins over scan");
      board_in = 64'd0; spawn_req = 1'b1; gen_done = 1'b0;
      tick();                                                 // cycle 1
      spawn_req = 1'b0;
      tick(); tick(); tick(); tick();                         // cycles 2..5
      chk("t5_c5_valid", 64'(spawn_valid), 64'd0);
      gen_done = 1'b1; gen_pos = 4'd15; gen_preset = 1'b0;   // sampled end of c5
      tick();                                                 // cycle 6 EMIT
      chk("t5_c6_valid", 64'(spawn_valid), 64'd1);
      chk("t5_pos",      64'(spawn_pos),   64'd15);
      chk("t5_exp",      64'(spawn_exp),   64'd1);
      chk("t5_bout",     board_out,        64'h1000_0000_0000_0000);
      gen_done = 1'b0;
      tick();

      // Reset during SEARCH aborts the operation. Then a clean request runs.
      $display("T6 reset during search then new request");
      board_in = 64'd0; spawn_req = 1'b1; gen_done = 1'b0;
      tick();                                                 // SETTLE
      spawn_req = 1'b0;
      tick();                                                 // SEARCH
      chk("t6_in_search_busy", 64'(spawn_busy), 64'd1);
      rst = 1'b0; gen_done = 1'b1; gen_pos = 4'd9; gen_preset = 1'b1;
      tick();
      chk_idle_zero("t6_rst");
      tick();
      chk("t6_rst2_valid", 64'(spawn_valid), 64'd0);
      rst = 1'b1; spawn_req = 1'b1;
      tick();                                                 // cycle 1
      chk("t6_c1_busy", 64'(spawn_busy), 64'd1);
      spawn_req = 1'b0;
      tick();                                                 // cycle 2
      chk("t6_c2_valid", 64'(spawn_valid), 64'd0);
      tick();                                                 // cycle 3 EMIT
      chk("t6_c3_valid", 64'(spawn_valid), 64'd1);
      chk("t6_pos",      64'(spawn_pos),   64'd9);
      chk("t6_exp",      64'(spawn_exp),   64'd2);
      chk("t6_bout",     board_out,        64'h0000_0020_0000_0000);
      gen_done = 1'b0;
      tick();
      chk("t6_c4_valid", 64'(spawn_valid), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
